// File: rtl/ram_scan_pkg.sv
// Shared types and segment constants for the lab RAM scan controller.
// Active-low 7-segment patterns, bit 6 = segment g.
package ram_scan_pkg;

  typedef enum logic [1:0] {
    StRead,
    StWait,
    StHold,
    StYield
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational hex digit to active-low 7-segment decoder.
module hex_seg_lut
  import ram_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/ram_scan_ctrl.sv
// Scan sequencer and RAM port arbiter with hex readout.
// HEX_ADDR_DISP_EN enables the address digit decoders; otherwise they are blanked.
module ram_scan_ctrl
  import ram_scan_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  step,
  input  logic                  wr_req,
  output logic                  wr_gnt,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [6:0]            data_hex,
  output logic [6:0]            addr_hex0,
  output logic [6:0]            addr_hex1
);

  localparam int unsigned DwellW = $clog2(DWELL_CYCLES);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);

  scan_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DwellW-1:0]     dwell_q, dwell_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  gnt_q, gnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRead;
      addr_q  <= '0;
      dwell_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dwell_q <= dwell_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dwell_d = '0;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      StRead: state_d = StWait;
      StWait: begin
        data_d  = rd_data;
        valid_d = 1'b1;
        state_d = wr_req ? StYield : StHold;
      end
      StHold: begin
        // Write requests win over scan and step; step is ignored while running.
        if (wr_req) begin
          state_d = StYield;
        end else if (run) begin
          if (dwell_q == DwellLast) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = StRead;
          end else begin
            dwell_d = dwell_q + DwellW'(1);
          end
        end else if (step) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = StRead;
        end
      end
      StYield: begin
        // Re-read the same address so any user write shows up.
        if (!wr_req) state_d = StRead;
      end
      default: state_d = StRead;
    endcase
    gnt_d = (state_d == StYield);
  end

  // Gated by reset so the port stays idle while held in reset.
  assign rd_en   = (state_q == StRead) & reset_n;
  assign wr_gnt  = gnt_q;
  assign rd_addr = addr_q;

  logic [6:0] data_seg;

  hex_seg_lut u_data_lut (
    .nibble(data_q[3:0]),
    .seg   (data_seg)
  );

  assign data_hex = valid_q ? data_seg : SEG_BLANK;

`ifdef HEX_ADDR_DISP_EN
  logic [3:0] addr_hi;
  assign addr_hi = 4'(addr_q >> 4);

  hex_seg_lut u_addr_lo_lut (
    .nibble(addr_q[3:0]),
    .seg   (addr_hex0)
  );

  hex_seg_lut u_addr_hi_lut (
    .nibble(addr_hi),
    .seg   (addr_hex1)
  );
`else
  assign addr_hex0 = SEG_BLANK;
  assign addr_hex1 = SEG_BLANK;
`endif

endmodule
